mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter for a single-port block memory inside the manta debug core. It lets the host bridge (UART-driven) and on-chip user logic share one memory port. Each requester issues reads and writes over a valid/ready request channel. Responses return over a fixed-latency response channel that is routed back to the originating requester. Arbitration is round-robin and fully pipelined: the block accepts one request per cycle with no bubbles.

## Interface
- ADDR_WIDTH, 16, memory address width
- DATA_WIDTH, 16, memory data width
- READ_LATENCY, 2, cycles from mem_en sampled to mem_rdata valid (>=1)

- clk  in  1  system clock, all logic rising-edge
- rst  in  1  reset, asynchronous, active-low
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready
- req0_we / req1_we  in  1  1 = write, 0 = read
- req0_addr / req1_addr  in  ADDR_WIDTH  target address
- req0_wdata / req1_wdata  in  DATA_WIDTH  write data
- rsp0_valid / rsp1_valid  out  1  one-cycle response strobe, no backpressure
- rsp0_rdata / rsp1_rdata  out  DATA_WIDTH  read data; 0 for write responses
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data
- busy  out  1  high while any accepted request has not yet responded

## Operation
- Grant pointer last_grant (1 bit) holds the last requester granted. Reset value 1, so requester 0 wins the first contention.
- Ready is combinational:
  - req0_ready = !req1_valid | (last_grant==1)
  - req1_ready = !req0_valid | (last_grant==0)
  - If both requesters are valid, exactly one is ready.
- On accept (valid&ready) of requester i:
  - last_grant <= i.
  - Request fields are registered onto mem_en=1, mem_we, mem_addr, mem_wdata.
  - The pipeline tag entry {valid=1, owner=i, we} is pushed.
- With no accept, mem_en=0 and mem_we=0 next cycle. mem_addr and mem_wdata hold their last values.
- Tag shift register is READ_LATENCY+1 stages deep and shifts every cycle. When the head stage is valid, owner o gets:
  - rsp<o>_valid <= 1
  - rsp<o>_rdata <= we ? 0 : mem_rdata
- The non-owner's rsp_valid is 0. Its rsp_rdata holds its previous value.
- Writes also produce a response (acknowledge), at the same latency as reads.
- busy = OR of all tag-stage valid bits, plus any rsp_valid currently high.
- Responses are returned in issue order. Owner routing comes only from the tag, never from current request state.

## Timing
- Accept at the edge ending cycle T:
  - mem_en high in cycle T+1.
  - mem_rdata valid in cycle T+1+READ_LATENCY.
  - rspN_valid high in cycle T+2+READ_LATENCY (T+4 with the default), for exactly one cycle.
- Throughput: one request per cycle. Back-to-back accepts produce back-to-back responses in the same order.
- Continuous contention alternates grants 0,1,0,1…
- A lone requester is granted every cycle regardless of last_grant.
- Reset values:
  - all ready outputs follow the combinational rule
  - mem_en, mem_we, mem_addr, mem_wdata = 0
  - rsp*_valid, rsp*_rdata = 0
  - busy = 0, last_grant = 1, tags cleared
- Reset mid-operation: all in-flight tags are discarded. No response is ever emitted for a request accepted before reset. Outputs go to reset values immediately (asynchronously).
- Same address, write then read in consecutive accepts: the read returns the new data. This holds because the memory is write-first and requests are issued strictly in order.
- Address width is used unmodified, so there is no wrap logic. wdata and rdata are passed bit-exact.

## Test plan
- Single read: req0 addr 0x0010 (memory holds 0xBEEF), accepted cycle 0 → mem_en cycle 1; rsp0_valid only in cycle 4 with 0xBEEF; rsp1_valid stays 0.
- Write then read: req1 writes 0x1234 to 0x0003, then reads 0x0003 next cycle → two rsp1 strobes in consecutive cycles, rdata 0x0000 then 0x1234.
- Contention: both valid for 4 cycles after reset → grants 0,1,0,1; responses alternate rsp0, rsp1, rsp0, rsp1 in cycles 4–7.
- Lone requester: req1 valid for 3 cycles with last_grant=1 → req1_ready high all 3 cycles; 3 consecutive rsp1 strobes.
- Reset mid-flight: assert rst low in cycle 2 after a read accepted in cycle 0 → rsp0_valid never asserts; busy and mem_en are 0 during reset.
- Busy: one write accepted in cycle 0 → busy high in cycles 1–4, low in cycle 5.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter letting two requesters share one single-port block memory.
// Fully pipelined: one accept per cycle, responses routed back by an in-order tag pipeline.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    // One tag stage per cycle between accept and the registered response.
    localparam int STAGES = READ_LATENCY + 1;
    localparam int HEAD   = STAGES - 1;

    logic                  last_grant_reg;
    logic                  mem_en_reg;
    logic                  mem_we_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic [DATA_WIDTH-1:0] mem_wdata_reg;
    logic [STAGES-1:0]     tag_valid_reg;
    logic [STAGES-1:0]     tag_owner_reg;
    logic [STAGES-1:0]     tag_we_reg;
    logic                  rsp0_valid_reg;
    logic                  rsp1_valid_reg;
    logic [DATA_WIDTH-1:0] rsp0_rdata_reg;
    logic [DATA_WIDTH-1:0] rsp1_rdata_reg;

    logic accept0;
    logic accept1;
    logic any_accept;
    logic sel_we;

    // Under contention the requester not granted last time wins.
    assign req0_ready = !req1_valid || last_grant_reg;
    assign req1_ready = !req0_valid || !last_grant_reg;

    assign accept0    = req0_valid && req0_ready;
    assign accept1    = req1_valid && req1_ready;
    assign any_accept = accept0 || accept1;
    assign sel_we     = accept1 ? req1_we : req0_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_reg   <= 1'b1;
            mem_en_reg       <= 1'b0;
            mem_we_reg       <= 1'b0;
            mem_addr_reg     <= '0;
            mem_wdata_reg    <= '0;
            tag_valid_reg[0] <= 1'b0;
            tag_owner_reg[0] <= 1'b0;
            tag_we_reg[0]    <= 1'b0;
        end else begin
            mem_en_reg       <= any_accept;
            mem_we_reg       <= any_accept && sel_we;
            tag_valid_reg[0] <= any_accept;
            tag_owner_reg[0] <= accept1;
            tag_we_reg[0]    <= sel_we;
            if (any_accept) begin
                last_grant_reg <= accept1;
                mem_addr_reg   <= accept1 ? req1_addr : req0_addr;
                mem_wdata_reg  <= accept1 ? req1_wdata : req0_wdata;
            end
        end
    end

    generate
        for (genvar gi = 1; gi < STAGES; gi++) begin : g_tag
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    tag_valid_reg[gi] <= 1'b0;
                    tag_owner_reg[gi] <= 1'b0;
                    tag_we_reg[gi]    <= 1'b0;
                end else begin
                    tag_valid_reg[gi] <= tag_valid_reg[gi-1];
                    tag_owner_reg[gi] <= tag_owner_reg[gi-1];
                    tag_we_reg[gi]    <= tag_we_reg[gi-1];
                end
            end
        end
    endgenerate

    // Head stage lines up with mem_rdata; owner comes only from the tag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp0_valid_reg <= 1'b0;
            rsp1_valid_reg <= 1'b0;
            rsp0_rdata_reg <= '0;
            rsp1_rdata_reg <= '0;
        end else begin
            rsp0_valid_reg <= tag_valid_reg[HEAD] && !tag_owner_reg[HEAD];
            rsp1_valid_reg <= tag_valid_reg[HEAD] && tag_owner_reg[HEAD];
            if (tag_valid_reg[HEAD] && !tag_owner_reg[HEAD])
                rsp0_rdata_reg <= tag_we_reg[HEAD] ? '0 : mem_rdata;
            if (tag_valid_reg[HEAD] && tag_owner_reg[HEAD])
                rsp1_rdata_reg <= tag_we_reg[HEAD] ? '0 : mem_rdata;
        end
    end

    assign mem_en     = mem_en_reg;
    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign rsp0_valid = rsp0_valid_reg;
    assign rsp1_valid = rsp1_valid_reg;
    assign rsp0_rdata = rsp0_rdata_reg;
    assign rsp1_rdata = rsp1_rdata_reg;
    assign busy       = (|tag_valid_reg) || rsp0_valid_reg || rsp1_valid_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a write-first block memory model
// of read latency 2 attached to the memory port.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid, req0_ready, req0_we;
    logic [15:0] req0_addr, req0_wdata;
    logic        req1_valid, req1_ready, req1_we;
    logic [15:0] req1_addr, req1_wdata;
    logic        rsp0_valid, rsp1_valid;
    logic [15:0] rsp0_rdata, rsp1_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .READ_LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory model: sampled on the mem_en cycle, data visible two cycles later.
    logic [15:0] mem_array [0:65535];
    logic [15:0] rd1 = 16'h0;
    logic [15:0] rd2 = 16'h0;
    assign mem_rdata = rd2;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem_array[mem_addr] <= mem_wdata;
                rd1 <= mem_wdata;
            end else begin
                rd1 <= mem_array[mem_addr];
            end
        end
        rd2 <= rd1;
    end

    always @(negedge clk) begin
        if (rst && req0_valid && req0_ready)
            $display("req0 accepted we=%0d addr=%h wdata=%h", req0_we, req0_addr, req0_wdata);
        if (rst && req1_valid && req1_ready)
            $display("req1 accepted we=%0d addr=%h wdata=%h", req1_we, req1_addr, req1_wdata);
        if (rsp0_valid) $display("rsp0 rdata=%h", rsp0_rdata);
        if (rsp1_valid) $display("rsp1 rdata=%h", rsp1_rdata);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic nc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle();
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = 16'h0; req0_wdata = 16'h0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = 16'h0; req1_wdata = 16'h0;
    endtask

    task automatic set0(input logic we, input logic [15:0] a, input logic [15:0] d);
        req0_valid = 1'b1; req0_we = we; req0_addr = a; req0_wdata = d;
    endtask

    task automatic set1(input logic we, input logic [15:0] a, input logic [15:0] d);
        req1_valid = 1'b1; req1_we = we; req1_addr = a; req1_wdata = d;
    endtask

    task automatic do_reset();
        idle();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem_array[i] = 16'h0;
        mem_array[16'h0010] = 16'hBEEF;
        mem_array[16'h0003] = 16'hAAAA;
        mem_array[16'h0020] = 16'h1111;
        mem_array[16'h0021] = 16'h2222;
        mem_array[16'h0030] = 16'h3000;
        mem_array[16'h0031] = 16'h3001;
        mem_array[16'h0032] = 16'h3002;
        idle();

        // Reset state, including the ready rule with last_grant=1
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        check("rst_rsp0_rdata", 32'(rsp0_rdata), 32'd0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("rst_rdy0_both", 32'(req0_ready), 32'd1);
        check("rst_rdy1_both", 32'(req1_ready), 32'd0);
        idle();
        #1;
        check("rst_rdy1_alone", 32'(req1_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;

        // Single read from requester 0
        for (int c = 0; c < 7; c++) begin
            nc();
            idle();
            if (c == 0) set0(1'b0, 16'h0010, 16'h0);
            mid();
            if (c == 0) check("rd_ready0", 32'(req0_ready), 32'd1);
            if (c == 1) begin
                check("rd_mem_en", 32'(mem_en), 32'd1);
                check("rd_mem_we", 32'(mem_we), 32'd0);
                check("rd_mem_addr", 32'(mem_addr), 32'h10);
            end
            if (c == 2) check("rd_mem_en_off", 32'(mem_en), 32'd0);
            if (c >= 1) begin
                check("rd_rsp0_valid", 32'(rsp0_valid), 32'(c == 4));
                check("rd_rsp1_valid", 32'(rsp1_valid), 32'd0);
            end
            if (c == 4) check("rd_rsp0_rdata", 32'(rsp0_rdata), 32'hBEEF);
        end

        // Requester 1 writes then reads the same address
        for (int c = 0; c < 7; c++) begin
            nc();
            idle();
            if (c == 0) set1(1'b1, 16'h0003, 16'h1234);
            if (c == 1) set1(1'b0, 16'h0003, 16'h0);
            mid();
            if (c == 1) begin
                check("wr_mem_we", 32'(mem_we), 32'd1);
                check("wr_mem_wdata", 32'(mem_wdata), 32'h1234);
            end
            check("wr_rsp1_valid", 32'(rsp1_valid), 32'(c == 4 || c == 5));
            check("wr_rsp0_valid", 32'(rsp0_valid), 32'd0);
            if (c == 4) check("wr_ack_rdata", 32'(rsp1_rdata), 32'h0);
            if (c == 5) check("wr_rd_rdata", 32'(rsp1_rdata), 32'h1234);
        end

        // Contention right after reset: grants 0,1,0,1
        do_reset();
        for (int c = 0; c < 9; c++) begin
            nc();
            idle();
            if (c < 4) begin
                set0(1'b0, 16'h0020, 16'h0);
                set1(1'b0, 16'h0021, 16'h0);
            end
            mid();
            if (c < 4) begin
                check("ct_ready0", 32'(req0_ready), 32'(c % 2 == 0));
                check("ct_ready1", 32'(req1_ready), 32'(c % 2 == 1));
            end else begin
                check("ct_rsp0_valid", 32'(rsp0_valid), 32'(c % 2 == 0 && c < 8));
                check("ct_rsp1_valid", 32'(rsp1_valid), 32'(c % 2 == 1));
                if (c % 2 == 0 && c < 8) check("ct_rsp0_rdata", 32'(rsp0_rdata), 32'h1111);
                if (c % 2 == 1) begin
                    check("ct_rsp1_rdata", 32'(rsp1_rdata), 32'h2222);
                    check("ct_rsp0_hold", 32'(rsp0_rdata), 32'h1111);
                end
            end
        end

        // Lone requester 1 with last_grant=1
        for (int c = 0; c < 8; c++) begin
            nc();
            idle();
            if (c < 3) set1(1'b0, 16'(16'h0030 + c), 16'h0);
            mid();
            if (c < 3) check("lone_ready1", 32'(req1_ready), 32'd1);
            if (c >= 3) check("lone_rsp1_valid", 32'(rsp1_valid), 32'(c >= 4 && c <= 6));
            if (c >= 4 && c <= 6) check("lone_rsp1_rdata", 32'(rsp1_rdata), 32'(16'h3000 + (c - 4)));
            check("lone_rsp0_valid", 32'(rsp0_valid), 32'd0);
        end

        // Reset while a read is in flight
        for (int c = 0; c < 8; c++) begin
            nc();
            idle();
            if (c == 0) set0(1'b0, 16'h0010, 16'h0);
            if (c == 2) begin
                rst = 1'b0;
                #1;
                check("mr_mem_en", 32'(mem_en), 32'd0);
                check("mr_busy", 32'(busy), 32'd0);
            end
            mid();
            if (c == 1) check("mr_busy_before", 32'(busy), 32'd1);
            if (c == 3) rst = 1'b1;
            check("mr_rsp0_valid", 32'(rsp0_valid), 32'd0);
        end

        // Busy window around a single write
        for (int c = 0; c < 7; c++) begin
            nc();
            idle();
            if (c == 0) set0(1'b1, 16'h0040, 16'h5A5A);
            mid();
            check("busy", 32'(busy), 32'(c >= 1 && c <= 4));
            if (c == 4) begin
                check("busy_rsp0_valid", 32'(rsp0_valid), 32'd1);
                check("busy_rsp0_rdata", 32'(rsp0_rdata), 32'h0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
